// File: rtl/frame_scan_sequencer.sv
// Double-buffered 64-slot charlieplex scan sequencer with frame-rate PWM brightness.
// Frame image swaps into the shadow register only in the LOAD slot between frames.
//
// state | meaning
// IDLE  | blanked, waiting for enable
// LOAD  | one cycle: shadow <= frame_in, ack any requested swap
// SCAN  | stepping through LED slots, DWELL_CYCLES per slot
// BLANK | one cycle after the last slot: advance frame_count and pwm_phase
module frame_scan_sequencer #(
    parameter int LED_COUNT    = 64,
    parameter int INDEX_W      = 6,
    parameter int DWELL_CYCLES = 4,
    parameter int PWM_BITS     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [LED_COUNT-1:0] frame_in,
    input  logic [PWM_BITS-1:0]  brightness,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic [INDEX_W-1:0]   charlie_index,
    output logic                 led_on,
    output logic                 frame_start,
    output logic [7:0]           frame_count
);

    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(LED_COUNT - 1);
    localparam logic [DW_W-1:0]    LAST_DW  = DW_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, BLANK} state_t;

    state_t               state, state_n;
    logic [LED_COUNT-1:0] shadow, shadow_n;
    logic [INDEX_W-1:0]   index_n;
    logic [DW_W-1:0]      dwell, dwell_n;
    logic [PWM_BITS-1:0]  pwm_phase, pwm_phase_n;
    logic                 pending, pending_n;
    logic [7:0]           frame_count_n;
    logic                 swap_ack_n, led_on_n, frame_start_n;

    always_comb begin
        state_n       = state;
        shadow_n      = shadow;
        index_n       = charlie_index;
        dwell_n       = dwell;
        pwm_phase_n   = pwm_phase;
        pending_n     = pending | swap_req;
        frame_count_n = frame_count;
        swap_ack_n    = 1'b0;

        case (state)
            IDLE: begin
                index_n = '0;
                dwell_n = '0;
                if (enable) begin
                    state_n    = LOAD;
                    swap_ack_n = pending | swap_req;
                end
            end
            LOAD: begin
                shadow_n  = frame_in;
                pending_n = 1'b0;
                state_n   = SCAN;
                index_n   = '0;
                dwell_n   = '0;
            end
            SCAN: begin
                if (!enable) begin
                    state_n = IDLE;
                    index_n = '0;
                    dwell_n = '0;
                end else if (dwell == LAST_DW) begin
                    dwell_n = '0;
                    if (charlie_index == LAST_IDX) begin
                        state_n       = BLANK;
                        frame_count_n = frame_count + 8'd1;
                        pwm_phase_n   = pwm_phase + 1'b1;
                    end else begin
                        index_n = charlie_index + 1'b1;
                    end
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            BLANK: begin
                dwell_n = '0;
                if (!enable) begin
                    state_n = IDLE;
                    index_n = '0;
                end else if (pending | swap_req) begin
                    state_n    = LOAD;
                    index_n    = '0;
                    swap_ack_n = 1'b1;
                end else begin
                    state_n = SCAN;
                    index_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so they are derived from the values about to be loaded.
        frame_start_n = (state_n == SCAN) && (index_n == '0) && (dwell_n == '0);
        led_on_n      = (state_n == SCAN) && shadow_n[index_n] && (brightness > pwm_phase_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shadow        <= '0;
            charlie_index <= '0;
            dwell         <= '0;
            pwm_phase     <= '0;
            pending       <= 1'b0;
            frame_count   <= 8'd0;
            swap_ack      <= 1'b0;
            led_on        <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            state         <= state_n;
            shadow        <= shadow_n;
            charlie_index <= index_n;
            dwell         <= dwell_n;
            pwm_phase     <= pwm_phase_n;
            pending       <= pending_n;
            frame_count   <= frame_count_n;
            swap_ack      <= swap_ack_n;
            led_on        <= led_on_n;
            frame_start   <= frame_start_n;
        end
    end

endmodule

// File: tb/tb_frame_scan_sequencer.sv
// Bench for frame_scan_sequencer: directed scenarios plus random traffic, every cycle
// compared against a frame-position model (scan time t, LED = t/DWELL, phase = frames mod 16).
module tb_frame_scan_sequencer;

    localparam int LED   = 64;
    localparam int DW    = 4;
    localparam int SCANT = LED * DW;
    localparam int M_IDLE = 0, M_LOAD = 1, M_SCAN = 2, M_BLANK = 3;

    logic        clk, rst, enable, swap_req;
    logic [63:0] frame_in;
    logic [3:0]  brightness;
    logic        swap_ack, led_on, frame_start;
    logic [5:0]  charlie_index;
    logic [7:0]  frame_count;

    frame_scan_sequencer dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_in(frame_in),
        .brightness(brightness), .swap_req(swap_req), .swap_ack(swap_ack),
        .charlie_index(charlie_index), .led_on(led_on),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    int          m_mode, m_t, m_fc;
    logic [63:0] m_shadow;
    logic        m_pend;
    logic        e_led, e_fs, e_ack;
    int          e_idx;
    int          ack_seen, led_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_t = 0; m_fc = 0; m_shadow = '0; m_pend = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied, clock the DUT, compare.
    task automatic step();
        e_ack = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (enable) begin
                    e_ack  = m_pend | swap_req;
                    m_mode = M_LOAD;
                end
                m_pend = m_pend | swap_req;
            end
            M_LOAD: begin
                m_shadow = frame_in;
                m_pend   = 1'b0;
                m_mode   = M_SCAN;
                m_t      = 0;
            end
            M_SCAN: begin
                m_pend = m_pend | swap_req;
                if (!enable) m_mode = M_IDLE;
                else if (m_t == SCANT - 1) begin
                    m_mode = M_BLANK;
                    m_fc   = m_fc + 1;
                end else m_t = m_t + 1;
            end
            default: begin
                m_pend = m_pend | swap_req;
                if (!enable) m_mode = M_IDLE;
                else if (m_pend) begin
                    m_mode = M_LOAD;
                    e_ack  = 1'b1;
                end else begin
                    m_mode = M_SCAN;
                    m_t    = 0;
                end
            end
        endcase
        e_led = 1'b0; e_fs = 1'b0; e_idx = 0;
        if (m_mode == M_SCAN) begin
            e_idx = m_t / DW;
            e_fs  = (m_t == 0);
            e_led = m_shadow[e_idx] && (int'(brightness) > (m_fc % 16));
        end else if (m_mode == M_BLANK) begin
            e_idx = LED - 1;
        end
        @(posedge clk);
        #1;
        chk("led_on", 64'(led_on), 64'(e_led));
        chk("index", 64'(charlie_index), 64'(e_idx));
        chk("frame_start", 64'(frame_start), 64'(e_fs));
        chk("swap_ack", 64'(swap_ack), 64'(e_ack));
        chk("frame_count", 64'(frame_count), 64'(m_fc % 256));
        ack_seen += int'(swap_ack);
        led_seen += int'(led_on);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    // Step until the model is in SCAN at scan-time t; bounded.
    task automatic wait_scan_t(input int t);
        int k;
        k = 0;
        while (!(m_mode == M_SCAN && m_t == t) && k < 1000) begin
            step();
            k++;
        end
        chk("wait_scan_t", 64'(k < 1000), 64'd1);
    endtask

    // Called just after an active edge: reset asynchronously, check mid-cycle, release.
    task automatic apply_reset();
        rst = 1'b1;
        #2;
        chk("rst_led_on", 64'(led_on), 64'd0);
        chk("rst_index", 64'(charlie_index), 64'd0);
        chk("rst_frame_start", 64'(frame_start), 64'd0);
        chk("rst_swap_ack", 64'(swap_ack), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int fc_saved, lit, led_before, ack_before;
        rst = 1'b0; enable = 1'b0; swap_req = 1'b0;
        frame_in = 64'h0; brightness = 4'd15;
        ack_seen = 0; led_seen = 0;
        #1;
        apply_reset();

        // Basic single-LED frame, two full frames.
        enable = 1'b1; frame_in = 64'h1;
        run(258);
        chk("first_blank_count", 64'(frame_count), 64'd1);
        run(257);

        // Live image changes without swap_req must not reach the display.
        ack_before = ack_seen;
        wait_scan_t(100);
        frame_in = 64'h8000_0000_0000_0000;
        run(400);
        chk("no_ack_without_req", 64'(ack_seen - ack_before), 64'd0);

        // Two requests in one frame collapse to one ack and one LOAD.
        ack_before = ack_seen;
        wait_scan_t(10 * DW);
        pulse_swap();
        wait_scan_t(20 * DW);
        pulse_swap();
        run(600);
        chk("single_ack", 64'(ack_seen - ack_before), 64'd1);

        // Brightness 4 lights only frames with phase 0..3 of 16.
        apply_reset();
        frame_in = '1; brightness = 4'd4;
        step();
        lit = 0;
        for (int f = 0; f < 16; f++) begin
            led_before = led_seen;
            run(257);
            if (led_seen > led_before) lit++;
        end
        chk("lit_frames_b4", 64'(lit), 64'd4);
        brightness = 4'd0;
        led_before = led_seen;
        run(600);
        chk("dark_b0", 64'(led_seen - led_before), 64'd0);

        // Enable drop mid-frame.
        brightness = 4'd15;
        wait_scan_t(30 * DW);
        fc_saved = int'(frame_count);
        enable = 1'b0;
        step();
        chk("drop_count_hold", 64'(frame_count), 64'(fc_saved));
        run(5);
        enable = 1'b1;
        run(300);

        // Reset with a swap pending: the next LOAD must not ack.
        wait_scan_t(10 * DW);
        pulse_swap();
        wait_scan_t(40 * DW);
        apply_reset();
        ack_before = ack_seen;
        run(300);
        chk("no_ack_after_rst", 64'(ack_seen - ack_before), 64'd0);

        // Random traffic.
        for (int i = 0; i < 20000; i++) begin
            swap_req = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) frame_in = {$urandom, $urandom};
            if ($urandom_range(0, 49) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1499) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            step();
        end
        swap_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
